// File: rtl/readout_order_gen.sv
// Readout sequencer: walks every query position in blocked or raster order, reads the
// index memory and streams the returned words through a 2-entry buffer with valid/ready.
module readout_order_gen #(
   parameter int unsigned DATA_WIDTH = 11,
   parameter int unsigned ROW_SIZE   = 26,
   parameter int unsigned COL_SIZE   = 19,
   parameter int unsigned NUM_SPLITS = 2,
   parameter int unsigned BLOCKING   = 4,
   parameter int unsigned ADDR_WIDTH = $clog2(ROW_SIZE*COL_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  raster_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_last
);
   localparam int unsigned SW    = ROW_SIZE / NUM_SPLITS;
   localparam int unsigned NXB   = (SW + BLOCKING - 1) / BLOCKING;
   localparam int unsigned LASTW = SW - (NXB - 1) * BLOCKING;
   localparam int unsigned TOTAL = ROW_SIZE * COL_SIZE;
   localparam int unsigned PX_W  = (NUM_SPLITS > 1) ? $clog2(NUM_SPLITS) : 1;
   localparam int unsigned X_W   = (NXB > 1) ? $clog2(NXB) : 1;
   localparam int unsigned Y_W   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
   localparam int unsigned XI_W  = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_busy, r_done, r_ren, r_ren_last, r_raster;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic [PX_W-1:0]       r_px, w_px_n;
   logic [X_W-1:0]        r_x, w_x_n;
   logic [Y_W-1:0]        r_y, w_y_n;
   logic [XI_W-1:0]       r_xi, w_xi_n, w_xi_max;
   logic [ADDR_WIDTH-1:0] r_lin, w_lin_n;
   logic [CNT_W-1:0]      r_issued;
   logic                  r_rv, r_rv_last;
   logic [ADDR_WIDTH-1:0] r_rv_addr;
   logic [DATA_WIDTH-1:0] r_buf_data [2];
   logic [ADDR_WIDTH-1:0] r_buf_addr [2];
   logic [1:0]            r_buf_last;
   logic                  r_wp, r_rp;
   logic [1:0]            r_cnt;
   logic                  w_issue, w_issue_last, w_done_nxt, w_mode, w_credit;
   logic                  w_buf_ne, w_pop, w_buf_pop, w_push;
   logic [ADDR_WIDTH-1:0] w_blk_addr, w_addr;

   // Output side: buffer head, or the returning word bypassed when the buffer is empty
   assign w_buf_ne  = (r_cnt != 2'd0);
   assign out_valid = w_buf_ne | r_rv;
   assign out_data  = w_buf_ne ? r_buf_data[r_rp] : (r_rv ? mem_rdata : '0);
   assign out_addr  = w_buf_ne ? r_buf_addr[r_rp] : (r_rv ? r_rv_addr : '0);
   assign out_last  = w_buf_ne ? r_buf_last[r_rp] : (r_rv & r_rv_last);
   assign w_pop     = out_valid & out_ready;
   assign w_buf_pop = w_buf_ne & out_ready;
   assign w_push    = r_rv & ~(~w_buf_ne & out_ready);

   // Held + returning + requested words, net of this cycle's pop, must stay within 2
   assign w_credit = (3'(r_cnt) + 3'(r_rv) + 3'(r_ren)) < (3'd2 + 3'(w_pop));

   assign busy      = r_busy;
   assign done      = r_done;
   assign mem_ren   = r_ren;
   assign mem_raddr = r_raddr;

   assign w_issue_last = (r_issued == CNT_W'(TOTAL - 1));
   assign w_mode       = (r_state == S_IDLE) ? raster_mode : r_raster;
   assign w_xi_max     = (r_x == X_W'(NXB - 1)) ? XI_W'(LASTW - 1) : XI_W'(BLOCKING - 1);
   assign w_blk_addr   = ADDR_WIDTH'(r_px) * ADDR_WIDTH'(SW)
                       + ADDR_WIDTH'(r_y) * ADDR_WIDTH'(ROW_SIZE)
                       + ADDR_WIDTH'(r_x) * ADDR_WIDTH'(BLOCKING)
                       + ADDR_WIDTH'(r_xi);
   assign w_addr       = r_raster ? r_lin : w_blk_addr;

   // Loop counters: lane innermost, then row, x-block, split
   always_comb begin
      w_px_n  = r_px;
      w_x_n   = r_x;
      w_y_n   = r_y;
      w_xi_n  = r_xi;
      w_lin_n = (r_lin == ADDR_WIDTH'(TOTAL - 1)) ? '0 : r_lin + ADDR_WIDTH'(1);
      if (r_xi != w_xi_max) begin
         w_xi_n = r_xi + XI_W'(1);
      end else begin
         w_xi_n = '0;
         if (r_y != Y_W'(COL_SIZE - 1)) begin
            w_y_n = r_y + Y_W'(1);
         end else begin
            w_y_n = '0;
            if (r_x != X_W'(NXB - 1)) begin
               w_x_n = r_x + X_W'(1);
            end else begin
               w_x_n  = '0;
               w_px_n = (r_px == PX_W'(NUM_SPLITS - 1)) ? '0 : r_px + PX_W'(1);
            end
         end
      end
   end

   // Next-state logic; the accepted start also issues the first read
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_issue     = 1'b1;
               w_state_nxt = w_issue_last ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (w_credit) begin
               w_issue = 1'b1;
               if (w_issue_last) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && out_last) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ren      <= 1'b0;
         r_ren_last <= 1'b0;
         r_raddr    <= '0;
         r_raster   <= 1'b0;
         r_px       <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_xi       <= '0;
         r_lin      <= '0;
         r_issued   <= '0;
         r_rv       <= 1'b0;
         r_rv_addr  <= '0;
         r_rv_last  <= 1'b0;
         r_buf_last <= '0;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_cnt      <= '0;
         for (int i = 0; i < 2; i++) begin
            r_buf_data[i] <= '0;
            r_buf_addr[i] <= '0;
         end
      end else begin
         r_busy     <= (w_state_nxt != S_IDLE);
         r_done     <= w_done_nxt;
         r_ren      <= w_issue;
         r_ren_last <= w_issue & w_issue_last;
         if (r_state == S_IDLE && start) r_raster <= raster_mode;
         if (w_issue) begin
            r_raddr  <= w_addr;
            r_issued <= w_issue_last ? '0 : r_issued + CNT_W'(1);
            if (w_mode) begin
               r_lin <= w_lin_n;
            end else begin
               r_px <= w_px_n;
               r_x  <= w_x_n;
               r_y  <= w_y_n;
               r_xi <= w_xi_n;
            end
         end
         r_rv      <= r_ren;
         r_rv_addr <= r_raddr;
         r_rv_last <= r_ren_last;
         if (w_push) begin
            r_buf_data[r_wp] <= mem_rdata;
            r_buf_addr[r_wp] <= r_rv_addr;
            r_buf_last[r_wp] <= r_rv_last;
            r_wp             <= ~r_wp;
         end
         if (w_buf_pop) r_rp <= ~r_rp;
         r_cnt <= r_cnt + 2'(w_push) - 2'(w_buf_pop);
      end
   end
endmodule

// File: tb/tb_readout_order_gen.sv
// Directed bench for readout_order_gen: default geometry plus a small 16x3 single-split instance.
module tb_readout_order_gen;
   localparam int unsigned DW      = 11;
   localparam int unsigned AW      = 9;
   localparam int unsigned AWB     = 6;
   localparam int unsigned TOTAL   = 494;
   localparam int unsigned TOTAL_B = 48;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start_a = 0, raster_a = 0, ready_a = 1;
   logic          busy_a, done_a, ren_a, valid_a, last_a;
   logic [AW-1:0] raddr_a, addr_a;
   logic [DW-1:0] rdata_a = '0, data_a;

   logic           start_b = 0, ready_b = 1;
   logic           busy_b, done_b, ren_b, valid_b, last_b;
   logic [AWB-1:0] raddr_b, addr_b;
   logic [DW-1:0]  rdata_b = '0, data_b;

   readout_order_gen dut_a (
      .clk(clk), .rst(rst), .start(start_a), .raster_mode(raster_a), .busy(busy_a), .done(done_a),
      .mem_ren(ren_a), .mem_raddr(raddr_a), .mem_rdata(rdata_a), .out_valid(valid_a),
      .out_ready(ready_a), .out_data(data_a), .out_addr(addr_a), .out_last(last_a));

   readout_order_gen #(.DATA_WIDTH(11), .ROW_SIZE(16), .COL_SIZE(3), .NUM_SPLITS(1), .BLOCKING(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .raster_mode(1'b0), .busy(busy_b), .done(done_b),
      .mem_ren(ren_b), .mem_raddr(raddr_b), .mem_rdata(rdata_b), .out_valid(valid_b),
      .out_ready(ready_b), .out_data(data_b), .out_addr(addr_b), .out_last(last_b));

   // Index memories: A holds value=addr, B holds addr+100
   always @(posedge clk) if (ren_a) rdata_a <= DW'(raddr_a);
   always @(posedge clk) if (ren_b) rdata_b <= DW'(raddr_b) + DW'(100);

   int n_cmp = 0, n_bad = 0;
   int ncyc = 0, iss = 0, acc = 0, stall_err = 0, outst_err = 0, done_a_cnt = 0, done_b_cnt = 0;
   int st_cyc = 0, fr_cyc = -1, fv_cyc = -1, la_cyc = 0, dn_cyc = 0;
   int qa_addr[$], qa_data[$], qa_last[$], qb_addr[$], qb_data[$], qb_last[$];
   bit prev_stall = 0;
   logic [DW-1:0] prev_data = '0;

   // Beat monitor, sampled on the falling edge
   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         iss = 0; acc = 0; prev_stall = 0;
      end else begin
         if (start_a && !busy_a) begin st_cyc = ncyc; fr_cyc = -1; fv_cyc = -1; end
         if (ren_a) begin iss++; if (fr_cyc < 0) fr_cyc = ncyc; end
         if (iss - acc > 2) outst_err++;
         if (valid_a && fv_cyc < 0) fv_cyc = ncyc;
         if (prev_stall && (!valid_a || data_a !== prev_data)) stall_err++;
         if (valid_a && ready_a) begin
            qa_addr.push_back(int'(addr_a)); qa_data.push_back(int'(data_a)); qa_last.push_back(int'(last_a));
            acc++;
            if (last_a) la_cyc = ncyc;
         end
         prev_stall = valid_a && !ready_a;
         prev_data  = data_a;
         if (done_a) begin done_a_cnt++; dn_cyc = ncyc; end
         if (valid_b && ready_b) begin
            qb_addr.push_back(int'(addr_b)); qb_data.push_back(int'(data_b)); qb_last.push_back(int'(last_b));
         end
         if (done_b) done_b_cnt++;
      end
   end

   // Mismatches between captured A beats and the blocked-order loop nest
   function automatic int blk_mism();
      int e = 0, i = 0, a;
      for (int px = 0; px < 2; px++)
         for (int x = 0; x < 4; x++)
            for (int y = 0; y < 19; y++)
               for (int xi = 0; xi < ((x == 3) ? 1 : 4); xi++) begin
                  a = px*13 + y*26 + x*4 + xi;
                  if (i >= qa_addr.size()) e++;
                  else if (qa_addr[i] != a || qa_data[i] != a || qa_last[i] != int'(i == TOTAL-1)) e++;
                  i++;
               end
      return e;
   endfunction

   task automatic run_pass_a(input bit rast, input bit rnd, input int mid_start, output bit to);
      int d0 = done_a_cnt;
      qa_addr.delete(); qa_data.delete(); qa_last.delete();
      @(posedge clk); #1;
      raster_a = rast; start_a = 1'b1; ready_a = 1'b1;
      to = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk); #1;
         start_a = (n == mid_start);
         ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (done_a_cnt != d0) begin to = 1'b0; break; end
      end
      start_a = 1'b0; ready_a = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy_a, done_a, ren_a, valid_a, last_a} !== 5'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy_a, done_a, ren_a, valid_a, last_a});
      end
      n_cmp++;
      if (raddr_a !== '0) begin n_bad++; $display("FAIL reset_raddr: got %0d want 0", raddr_a); end
      n_cmp++;
      if (data_a !== '0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", data_a); end
      n_cmp++;
      if (addr_a !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
   endtask

   task automatic test_blocked();
      bit to;
      int d0 = done_a_cnt, e;
      int exp8[8] = '{0, 1, 2, 3, 26, 27, 28, 29};
      run_pass_a(1'b0, 1'b0, -1, to);
      repeat (4) @(posedge clk);
      n_cmp++;
      if (to !== 1'b0) begin n_bad++; $display("FAIL blk_timeout: done not seen"); end
      n_cmp++;
      if (qa_addr.size() != TOTAL) begin n_bad++; $display("FAIL blk_count: got %0d want %0d", qa_addr.size(), TOTAL); end
      if (qa_addr.size() == TOTAL) begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (qa_addr[i] != exp8[i]) begin n_bad++; $display("FAIL blk_first[%0d]: got %0d want %0d", i, qa_addr[i], exp8[i]); end
         end
         n_cmp++;
         if ({qa_addr[228], qa_addr[229], qa_addr[230]} != {32'd12, 32'd38, 32'd64}) begin
            n_bad++; $display("FAIL blk_partial: got %0d,%0d,%0d want 12,38,64", qa_addr[228], qa_addr[229], qa_addr[230]);
         end
         n_cmp++;
         if (qa_addr[247] != 13) begin n_bad++; $display("FAIL blk_split1: got %0d want 13", qa_addr[247]); end
         n_cmp++;
         if (qa_addr[TOTAL-1] != 493 || qa_last[TOTAL-1] != 1) begin
            n_bad++; $display("FAIL blk_last: got addr %0d last %0d want 493/1", qa_addr[TOTAL-1], qa_last[TOTAL-1]);
         end
      end
      e = blk_mism();
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL blk_order: got %0d wrong beats want 0", e); end
      n_cmp++;
      if (fr_cyc - st_cyc != 1) begin n_bad++; $display("FAIL blk_issue_lat: got %0d want 1", fr_cyc - st_cyc); end
      n_cmp++;
      if (fv_cyc - st_cyc != 2) begin n_bad++; $display("FAIL blk_valid_lat: got %0d want 2", fv_cyc - st_cyc); end
      n_cmp++;
      if (done_a_cnt - d0 != 1) begin n_bad++; $display("FAIL blk_done_cnt: got %0d want 1", done_a_cnt - d0); end
      n_cmp++;
      if (dn_cyc != la_cyc + 1) begin n_bad++; $display("FAIL blk_done_time: got %0d want %0d", dn_cyc, la_cyc + 1); end
      n_cmp++;
      if (busy_a !== 1'b0) begin n_bad++; $display("FAIL blk_busy_end: got %b want 0", busy_a); end
   endtask

   task automatic test_raster();
      bit to;
      int d0 = done_a_cnt, e = 0;
      run_pass_a(1'b1, 1'b0, -1, to);
      for (int i = 0; i < qa_addr.size(); i++)
         if (qa_addr[i] != i || qa_data[i] != i || qa_last[i] != int'(i == TOTAL-1)) e++;
      n_cmp++;
      if (to !== 1'b0 || qa_addr.size() != TOTAL) begin
         n_bad++; $display("FAIL ras_count: got %0d beats (timeout %0b) want %0d", qa_addr.size(), to, TOTAL);
      end
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL ras_order: got %0d wrong beats want 0", e); end
      n_cmp++;
      if (done_a_cnt - d0 != 1) begin n_bad++; $display("FAIL ras_done: got %0d want 1", done_a_cnt - d0); end
   endtask

   task automatic test_backpressure();
      bit to;
      int d0 = done_a_cnt, s0 = stall_err, o0 = outst_err, e;
      run_pass_a(1'b0, 1'b1, -1, to);
      e = blk_mism();
      n_cmp++;
      if (to !== 1'b0 || qa_addr.size() != TOTAL) begin
         n_bad++; $display("FAIL bp_count: got %0d beats (timeout %0b) want %0d", qa_addr.size(), to, TOTAL);
      end
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL bp_order: got %0d wrong beats want 0", e); end
      n_cmp++;
      if (stall_err != s0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err - s0); end
      n_cmp++;
      if (outst_err != o0) begin n_bad++; $display("FAIL bp_outstanding: got %0d cycles over 2 want 0", outst_err - o0); end
      n_cmp++;
      if (done_a_cnt - d0 != 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", done_a_cnt - d0); end
   endtask

   task automatic test_mid_start();
      bit to;
      int d0 = done_a_cnt, e;
      run_pass_a(1'b0, 1'b0, 50, to);
      repeat (10) @(posedge clk);
      e = blk_mism();
      n_cmp++;
      if (to !== 1'b0 || e != 0 || qa_addr.size() != TOTAL) begin
         n_bad++; $display("FAIL mid_start_order: got %0d wrong of %0d beats want 0 of %0d", e, qa_addr.size(), TOTAL);
      end
      n_cmp++;
      if (done_a_cnt - d0 != 1 || busy_a !== 1'b0) begin
         n_bad++; $display("FAIL mid_start_done: got %0d dones busy %b want 1 / 0", done_a_cnt - d0, busy_a);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int d0 = done_a_cnt;
      qa_addr.delete(); qa_data.delete(); qa_last.delete();
      @(posedge clk); #1;
      raster_a = 1'b0; start_a = 1'b1; ready_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int n = 0; n < 400 && qa_addr.size() < 100; n++) begin
         @(posedge clk); #1;
      end
      ready_a = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (qa_addr.size() != 100) begin n_bad++; $display("FAIL rstmid_beats: got %0d want 100", qa_addr.size()); end
      n_cmp++;
      if ({busy_a, done_a, ren_a, valid_a, last_a} !== 5'b0 || addr_a !== '0 || data_a !== '0) begin
         n_bad++; $display("FAIL rstmid_outputs: got ctrl %b addr %0d data %0d want 0", {busy_a, done_a, ren_a, valid_a, last_a}, addr_a, data_a);
      end
      repeat (5) @(posedge clk);
      #1 ready_a = 1'b1;
      n_cmp++;
      if (done_a_cnt != d0 || busy_a !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_nodone: got %0d dones busy %b want 0 / 0", done_a_cnt - d0, busy_a);
      end
      run_pass_a(1'b0, 1'b0, -1, to);
      n_cmp++;
      if (to !== 1'b0 || qa_addr.size() != TOTAL || qa_addr[0] != 0 || blk_mism() != 0) begin
         n_bad++; $display("FAIL rstmid_restart: got %0d beats first %0d want %0d first 0", qa_addr.size(), (qa_addr.size() > 0) ? qa_addr[0] : -1, TOTAL);
      end
   endtask

   task automatic test_small();
      int d0 = done_b_cnt, e = 0, i = 0, a;
      int exp9[9] = '{0, 1, 2, 3, 16, 17, 18, 19, 32};
      qb_addr.delete(); qb_data.delete(); qb_last.delete();
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      for (int n = 0; n < 500 && done_b_cnt == d0; n++) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (qb_addr.size() != TOTAL_B) begin n_bad++; $display("FAIL small_count: got %0d want %0d", qb_addr.size(), TOTAL_B); end
      if (qb_addr.size() == TOTAL_B) begin
         for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (qb_addr[k] != exp9[k]) begin n_bad++; $display("FAIL small_first[%0d]: got %0d want %0d", k, qb_addr[k], exp9[k]); end
         end
         n_cmp++;
         if (qb_addr[TOTAL_B-1] != 47 || qb_last[TOTAL_B-1] != 1) begin
            n_bad++; $display("FAIL small_last: got addr %0d last %0d want 47/1", qb_addr[TOTAL_B-1], qb_last[TOTAL_B-1]);
         end
      end
      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 3; y++)
            for (int xi = 0; xi < 4; xi++) begin
               a = y*16 + x*4 + xi;
               if (i >= qb_addr.size()) e++;
               else if (qb_addr[i] != a || qb_data[i] != a + 100 || qb_last[i] != int'(i == TOTAL_B-1)) e++;
               i++;
            end
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL small_order: got %0d wrong beats want 0", e); end
      n_cmp++;
      if (done_b_cnt - d0 != 1) begin n_bad++; $display("FAIL small_done: got %0d want 1", done_b_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_blocked();
      test_raster();
      test_backpressure();
      test_mid_start();
      test_reset_mid();
      test_small();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
